i3c_apb_cmd_master: RTL and testbench

- APB requester (initiator) that drives the register-side APB port of the I3C register block (PSEL/PENA/PADDR[11:2]/PWRITE/PWDATA, returns PRDATA/PREADY/wr_err).
- Converts a valid/ready command stream from the system/DMA side into single APB transfers.
- Returns one valid/ready response per command: read data, error, timeout.
- Used as the firmware-less register sequencer and as the bus driver in block-level benches.

---
 rtl/i3c_apb_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_i3c_apb_cmd_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_apb_cmd_master.sv
// APB requester: turns a valid/ready command stream into single APB transfers with one response each.
// Optional ACCESS-phase timeout is built when I3C_APB_MST_TIMEOUT_EN is defined.
module i3c_apb_cmd_master #(
  parameter int ADDR_HI     = 11,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int ERRCNT_W    = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_HI-2:0]  cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                PSEL,
  output logic                PENA,
  output logic [ADDR_HI:2]    PADDR,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                wr_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  logic [1:0]          r_state;
  logic                r_cmd_ready;
  logic                r_psel;
  logic                r_pena;
  logic [ADDR_HI:2]    r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_busy;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic w_accept;
  logic w_err_sat;

  assign w_accept  = r_cmd_ready & cmd_valid;
  assign w_err_sat = &r_err_cnt;

`ifdef I3C_APB_MST_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_to_cnt;
  logic       r_rsp_timeout;

  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_pena      <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cnt   <= '0;
`ifdef I3C_APB_MST_TIMEOUT_EN
      r_to_cnt      <= 8'd0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_pena  <= 1'b1;
          r_state <= ST_ACCESS;
`ifdef I3C_APB_MST_TIMEOUT_EN
          r_to_cnt <= 8'd0;
`endif
        end
        ST_ACCESS: begin
          // A completing PREADY takes priority over the timeout limit.
          if (PREADY) begin
            r_psel      <= 1'b0;
            r_pena      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= r_pwrite & wr_err;
            if (r_pwrite && wr_err && !w_err_sat) begin
              r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end
            r_state     <= ST_RESP;
`ifdef I3C_APB_MST_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_psel        <= 1'b0;
            r_pena        <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            if (!w_err_sat) begin
              r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end
            r_state       <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign PSEL      = r_psel;
  assign PENA      = r_pena;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_i3c_apb_cmd_master.sv
// Self-checking bench for i3c_apb_cmd_master: vector table, hand sequences and randomized transfers.
module tb_i3c_apb_cmd_master;

  localparam int TO_CYC = 16;
  localparam int ECW    = 4;
  localparam int ERRMAX = (1 << ECW) - 1;
`ifdef I3C_APB_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [9:0]      cmd_addr = '0;
  logic [31:0]     cmd_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            rsp_timeout;
  logic            busy;
  logic [ECW-1:0]  err_cnt;
  logic            PSEL;
  logic            PENA;
  logic [11:2]     PADDR;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic [31:0]     PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            wr_err = 1'b0;

  always #5 sys_clk = ~sys_clk;

  i3c_apb_cmd_master #(
    .ADDR_HI(11), .DATA_W(32), .TIMEOUT_CYC(TO_CYC), .ERRCNT_W(ECW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .err_cnt(err_cnt),
    .PSEL(PSEL), .PENA(PENA), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .wr_err(wr_err)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        werr;
    int          rdly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int exp_errcnt = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got 0x%0h, required 0x%0h", tag, what, act, exp);
    end
  endtask

  // Reference: response follows directly from the command, slave behaviour and timeout limit.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_to    = TO_EN && (v.waits >= TO_CYC);
    r.exp_rdata = (v.wr || r.exp_to) ? 32'h0 : v.prdata;
    r.exp_err   = r.exp_to || (v.wr && v.werr);
    return r;
  endfunction

  task automatic apply(input string tag, input vec_t v, input bit chain, input vec_t nxt);
    int acc;
    int ticks;
    int exp_acc;
    bit bus_ok;
    bit hold_ok;
    check(tag, "idle_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check(tag, "setup_psel", {31'd0, PSEL}, 32'd1);
    check(tag, "setup_pena", {31'd0, PENA}, 32'd0);
    check(tag, "setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check(tag, "setup_busy", {31'd0, busy}, 32'd1);
    acc = 0; ticks = 0; bus_ok = 1'b1;
    while (rsp_valid !== 1'b1 && ticks < 200) begin
      if (PSEL !== 1'b1 || PADDR !== v.addr || PWRITE !== v.wr || (v.wr && PWDATA !== v.wdata))
        bus_ok = 1'b0;
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 10'($urandom); cmd_wdata = $urandom;
      if (PENA === 1'b1) begin
        acc++;
        if (acc == v.waits + 1) begin
          PREADY = 1'b1; PRDATA = v.prdata; wr_err = v.werr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; wr_err = 1'($urandom);
        end
      end else begin
        PREADY = 1'b0;
      end
      tick();
      ticks++;
    end
    PREADY = 1'b0; wr_err = 1'b0;
    exp_acc = v.exp_to ? TO_CYC : v.waits + 1;
    check(tag, "bus_stable", {31'd0, bus_ok}, 32'd1);
    check(tag, "access_cycles", acc, exp_acc);
    check(tag, "rsp_latency", ticks, exp_acc + 1);
    check(tag, "rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check(tag, "resp_psel", {31'd0, PSEL}, 32'd0);
    check(tag, "resp_pena", {31'd0, PENA}, 32'd0);
    check(tag, "rsp_rdata", rsp_rdata, v.exp_rdata);
    check(tag, "rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    check(tag, "rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
    if (v.exp_err && exp_errcnt < ERRMAX) exp_errcnt++;
    check(tag, "err_cnt", {28'd0, err_cnt}, exp_errcnt);
    hold_ok = 1'b1;
    for (int i = 0; i < v.rdly; i++) begin
      if (chain) begin
        cmd_valid = 1'b1; cmd_write = nxt.wr; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata;
      end else begin
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
        cmd_addr = 10'($urandom); cmd_wdata = $urandom;
      end
      PREADY = 1'($urandom);
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
          rsp_timeout !== v.exp_to || PSEL !== 1'b0 || cmd_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    PREADY = 1'b0;
    if (v.rdly > 0) check(tag, "rsp_hold", {31'd0, hold_ok}, 32'd1);
    if (chain) begin
      cmd_valid = 1'b1; cmd_write = nxt.wr; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata;
    end else begin
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check(tag, "post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check(tag, "post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check(tag, "post_busy", {31'd0, busy}, 32'd0);
    check(tag, "post_psel", {31'd0, PSEL}, 32'd0);
    $display("xfer %s wr=%0d addr=0x%03h waits=%0d rdata=0x%08h err=%0d to=%0d err_cnt=%0d",
             tag, v.wr, v.addr, v.waits, rsp_rdata, rsp_err, rsp_timeout, err_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[9];
  vec_t v;
  vec_t dummy;

  initial begin
    tbl[0] = '{1'b1, 10'h004, 32'hA5A5_1234, 0, 32'h7777_7777, 1'b0, 0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 10'h010, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 10'h020, 32'h1111_2222, 0, 32'h3333_4444, 1'b1, 0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 10'h024, 32'h9999_9999, 1, 32'h1234_5678, 1'b1, 2, 32'h1234_5678, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 10'h3FF, 32'h0, TO_CYC - 1, 32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 10'h000, 32'h5555_AAAA, TO_CYC, 32'h0, 1'b0, 0, 32'h0, TO_EN, TO_EN};
    tbl[6] = '{1'b0, 10'h155, 32'h0, TO_CYC + 4, 32'h0BAD_C0DE, 1'b0, 1,
               (TO_EN ? 32'h0 : 32'h0BAD_C0DE), TO_EN, TO_EN};
    tbl[7] = '{1'b1, 10'h2AA, 32'hFFFF_FFFF, 2, 32'h0, 1'b1, 10, 32'h0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 10'h0AB, 32'h0, 0, 32'h5A5A_5A5A, 1'b0, 0, 32'h5A5A_5A5A, 1'b0, 1'b0};
    dummy = tbl[0];

    // Reset state
    sys_rst = 1'b1;
    repeat (3) tick();
    check("reset", "cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset", "rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset", "busy", {31'd0, busy}, 32'd0);
    check("reset", "err_cnt", {28'd0, err_cnt}, 32'd0);
    check("reset", "psel", {31'd0, PSEL}, 32'd0);
    check("reset", "pena", {31'd0, PENA}, 32'd0);
    check("reset", "paddr", {22'd0, PADDR}, 32'd0);
    check("reset", "pwdata", PWDATA, 32'd0);
    check("reset", "rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
    sys_rst = 1'b0;
    tick();
    check("reset", "ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // Vector table; entry 7 holds the response while the next command waits
    for (int i = 0; i < 9; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i], (i == 7), (i == 7) ? tbl[8] : dummy);
    end

    // Randomized transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom); v.addr = 10'($urandom); v.wdata = $urandom;
      v.waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO_CYC - 1, TO_CYC + 3))
                                            : int'($urandom_range(0, 4));
      v.prdata = $urandom; v.werr = 1'($urandom); v.rdly = int'($urandom_range(0, 3));
      v = model(v);
      apply($sformatf("rnd%0d", i), v, 1'b0, dummy);
    end

    // Error counter saturation
    for (int i = 0; i < ERRMAX + 4; i++) begin
      v.wr = 1'b1; v.addr = 10'($urandom); v.wdata = $urandom; v.waits = 0;
      v.prdata = $urandom; v.werr = 1'b1; v.rdly = 0;
      v = model(v);
      apply($sformatf("sat%0d", i), v, 1'b0, dummy);
    end
    check("sat", "err_cnt_max", {28'd0, err_cnt}, ERRMAX);

    // Reset pulse during ACCESS with a completing PREADY pending
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h01C; cmd_wdata = 32'h0F0F_0F0F;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_mid", "in_access", {30'd0, PSEL, PENA}, 32'd3);
    PREADY = 1'b1; wr_err = 1'b1; PRDATA = 32'h1357_9BDF; sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0; PREADY = 1'b0; wr_err = 1'b0;
    exp_errcnt = 0;
    check("rst_mid", "psel", {31'd0, PSEL}, 32'd0);
    check("rst_mid", "pena", {31'd0, PENA}, 32'd0);
    check("rst_mid", "rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid", "busy", {31'd0, busy}, 32'd0);
    check("rst_mid", "err_cnt", {28'd0, err_cnt}, 32'd0);
    tick();
    check("rst_mid", "ready_again", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid", "no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    $display("xfer rst_mid aborted by reset err_cnt=%0d", err_cnt);

    // Recovery transfer after the mid-operation reset
    apply("post_rst", tbl[1], 1'b0, dummy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
